// File: rtl/dmac_pkg.sv
// Shared encodings for the DMA controller.
// htrans_e matches the AHB HTRANS field; dmac_burst_state_e is the per-channel
// transfer state. Other DMA blocks reuse both encodings, so keep values stable.
package dmac_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_RD_HOLD = 3'd2,
        ST_WRITE   = 3'd3,
        ST_WR_HOLD = 3'd4,
        ST_DONE    = 3'd5
    } dmac_burst_state_e;

endpackage

// File: rtl/dmac_burst_ctrl_if.sv
// Channel-side bundle for dmac_burst_ctrl.
// master : the burst controller (drives the AHB control, FIFO strobes and irqs)
// slave  : the register file / AHB port / FIFO side that feeds it
// Control : start, pause, abort, tsize, bsize
// AHB     : hready, hresp in; htrans, hwrite out
// FIFO    : fifo_full, fifo_empty in; fifo_wr, fifo_rd out
// Status  : src_inc, dst_inc, busy, done_irq, err_irq, remaining
interface dmac_burst_ctrl_if
    import dmac_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int BSZ_W = 5
);
    logic             start;
    logic             pause;
    logic             abort;
    logic [CNT_W-1:0] tsize;
    logic [BSZ_W-1:0] bsize;
    logic             hready;
    logic             hresp;
    logic             fifo_full;
    logic             fifo_empty;
    htrans_e          htrans;
    logic             hwrite;
    logic             fifo_wr;
    logic             fifo_rd;
    logic             src_inc;
    logic             dst_inc;
    logic             busy;
    logic             done_irq;
    logic             err_irq;
    logic [CNT_W-1:0] remaining;

    modport master (
        input  start, pause, abort, tsize, bsize, hready, hresp, fifo_full, fifo_empty,
        output htrans, hwrite, fifo_wr, fifo_rd, src_inc, dst_inc, busy, done_irq,
               err_irq, remaining
    );

    modport slave (
        output start, pause, abort, tsize, bsize, hready, hresp, fifo_full, fifo_empty,
        input  htrans, hwrite, fifo_wr, fifo_rd, src_inc, dst_inc, busy, done_irq,
               err_irq, remaining
    );

endinterface

// File: rtl/dmac_xfer_counter.sv
// Remaining-beat, in-burst beat and effective-burst-length counters.
// Inputs : load (latch tsize/bsize), beat_done (a beat completed),
//          burst_start (recompute blen for the next read burst),
//          phase (0 = read, 1 = write; only write beats consume remaining)
// Outputs: last_beat (current beat is the last of the burst),
//          zero (the current write beat is the final beat of the transfer),
//          remaining, beat_cnt
module dmac_xfer_counter
    import dmac_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int BURST_MAX = 16,
    parameter int BSZ_W     = $clog2(BURST_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             beat_done,
    input  logic             burst_start,
    input  logic             phase,
    input  logic [CNT_W-1:0] tsize,
    input  logic [BSZ_W-1:0] bsize,
    output logic             last_beat,
    output logic             zero,
    output logic [CNT_W-1:0] remaining,
    output logic [BSZ_W-1:0] beat_cnt
);

    localparam int W = (CNT_W > BSZ_W) ? CNT_W : BSZ_W;

    logic [CNT_W-1:0] rem_q, rem_d;
    logic [BSZ_W-1:0] beat_q, beat_d;
    logic [BSZ_W-1:0] blen_q, blen_d;
    logic [BSZ_W-1:0] bsize_q;

    // blen = min(max(bsize,1), BURST_MAX, remaining), computed at a common width
    function automatic logic [BSZ_W-1:0] clip_blen(input logic [BSZ_W-1:0] bsz,
                                                   input logic [CNT_W-1:0] rem);
        logic [W-1:0] b;
        b = W'(bsz);
        if (b == '0)
            b = W'(1);
        if (b > W'(BURST_MAX))
            b = W'(BURST_MAX);
        if (W'(rem) < b)
            b = W'(rem);
        return b[BSZ_W-1:0];
    endfunction

    always_comb begin
        rem_d  = rem_q;
        beat_d = beat_q;
        blen_d = blen_q;
        if (load) begin
            rem_d  = tsize;
            beat_d = '0;
            blen_d = clip_blen(bsize, tsize);
        end else begin
            if (beat_done) begin
                beat_d = last_beat ? '0 : beat_q + BSZ_W'(1);
                if (phase && rem_q != '0)
                    rem_d = rem_q - CNT_W'(1);
            end
            // uses the post-decrement count so the final burst is shortened
            if (burst_start)
                blen_d = clip_blen(bsize_q, rem_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            beat_q  <= '0;
            blen_q  <= '0;
            bsize_q <= '0;
        end else begin
            rem_q  <= rem_d;
            beat_q <= beat_d;
            blen_q <= blen_d;
            if (load)
                bsize_q <= bsize;
        end
    end

    assign last_beat = (beat_q == blen_q - BSZ_W'(1));
    assign zero      = (rem_q == CNT_W'(1));
    assign remaining = rem_q;
    assign beat_cnt  = beat_q;

endmodule

// File: rtl/dmac_burst_ctrl.sv
// Per-channel DMA transfer controller: alternates read bursts (into the channel
// FIFO) and write bursts (out of it) until the programmed beat count is moved.
// Supports beat-granular pause/resume, abort, and error termination on HRESP.
// Ports: clk, rst (async, active-high), bus (dmac_burst_ctrl_if.master).
module dmac_burst_ctrl
    import dmac_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int BURST_MAX = 16,
    parameter int BSZ_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    dmac_burst_ctrl_if.master   bus
);

    dmac_burst_state_e state_q, state_d;
    logic              nseq_q, nseq_d;   // next issued beat must be NONSEQ (after resume)

    logic             load, beat_done, burst_start, phase;
    logic             last_beat, zero;
    logic [CNT_W-1:0] remaining;
    logic [BSZ_W-1:0] beat_cnt;
    logic             first, stall;

    htrans_e htrans;
    logic    hwrite, fifo_wr, fifo_rd, src_inc, dst_inc, done_irq, err_irq;

    dmac_xfer_counter #(
        .CNT_W     (CNT_W),
        .BURST_MAX (BURST_MAX),
        .BSZ_W     (BSZ_W)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .beat_done   (beat_done),
        .burst_start (burst_start),
        .phase       (phase),
        .tsize       (bus.tsize),
        .bsize       (bus.bsize),
        .last_beat   (last_beat),
        .zero        (zero),
        .remaining   (remaining),
        .beat_cnt    (beat_cnt)
    );

    assign phase = (state_q == ST_WRITE);
    assign first = (beat_cnt == '0) || nseq_q;
    assign stall = (state_q == ST_WRITE) ? bus.fifo_empty : bus.fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            nseq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nseq_q  <= nseq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        nseq_d      = nseq_q;
        htrans      = HT_IDLE;
        hwrite      = 1'b0;
        fifo_wr     = 1'b0;
        fifo_rd     = 1'b0;
        src_inc     = 1'b0;
        dst_inc     = 1'b0;
        done_irq    = 1'b0;
        err_irq     = 1'b0;
        load        = 1'b0;
        beat_done   = 1'b0;
        burst_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    nseq_d  = 1'b0;
                    state_d = (bus.tsize == '0) ? ST_DONE : ST_READ;
                end
            end

            ST_READ, ST_WRITE: begin
                if (bus.abort) begin
                    // abort wins over error, completion and pause alike
                    state_d = ST_IDLE;
                    nseq_d  = 1'b0;
                end else begin
                    hwrite = (state_q == ST_WRITE);
                    // while stalled, BUSY is only legal inside a running burst
                    if (stall)
                        htrans = first ? HT_IDLE : HT_BUSY;
                    else
                        htrans = first ? HT_NONSEQ : HT_SEQ;

                    if (!stall && bus.hready && bus.hresp) begin
                        err_irq = 1'b1;
                        state_d = ST_IDLE;
                        nseq_d  = 1'b0;
                    end else if (!stall && bus.hready) begin
                        beat_done = 1'b1;
                        nseq_d    = 1'b0;
                        if (state_q == ST_READ) begin
                            fifo_wr = 1'b1;
                            src_inc = 1'b1;
                        end else begin
                            fifo_rd = 1'b1;
                            dst_inc = 1'b1;
                        end
                        if (last_beat) begin
                            // a pause at a burst boundary parks in the next phase's hold
                            if (state_q == ST_READ) begin
                                state_d = bus.pause ? ST_WR_HOLD : ST_WRITE;
                            end else if (zero) begin
                                state_d = ST_DONE;
                            end else begin
                                burst_start = 1'b1;
                                state_d     = bus.pause ? ST_RD_HOLD : ST_READ;
                            end
                        end else if (bus.pause) begin
                            state_d = (state_q == ST_READ) ? ST_RD_HOLD : ST_WR_HOLD;
                        end
                    end else if (stall && bus.pause) begin
                        state_d = (state_q == ST_READ) ? ST_RD_HOLD : ST_WR_HOLD;
                    end
                end
            end

            ST_RD_HOLD, ST_WR_HOLD: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    nseq_d  = 1'b0;
                end else if (!bus.pause) begin
                    state_d = (state_q == ST_RD_HOLD) ? ST_READ : ST_WRITE;
                    nseq_d  = 1'b1;
                end
            end

            ST_DONE: begin
                done_irq = !bus.abort;
                state_d  = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.htrans    = htrans;
    assign bus.hwrite    = hwrite;
    assign bus.fifo_wr   = fifo_wr;
    assign bus.fifo_rd   = fifo_rd;
    assign bus.src_inc   = src_inc;
    assign bus.dst_inc   = dst_inc;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done_irq  = done_irq;
    assign bus.err_irq   = err_irq;
    assign bus.remaining = remaining;

endmodule
